// File: rtl/tick_scheduler_pkg.sv
// Shared types and helpers for the tick scheduler.
//   state_e     : sequencer states (IDLE, RUN, PAUSE)
//   Default*    : default period/level-count constants
//   calc_limit  : tick period in clk cycles for a given speed level
package tick_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam int unsigned DefaultBaseDiv   = 25000000;
  localparam int unsigned DefaultNumLevels = 8;

  // Each level halves the period of the previous one.
  function automatic logic [31:0] calc_limit(input logic [31:0] base, input logic [7:0] level);
    return base >> level;
  endfunction

endpackage

// File: rtl/rate_counter.sv
// Free-running modulo counter used as the tick-rate divider.
//   clk, rst : clock, asynchronous active-high reset
//   en       : advance the count this cycle
//   clr      : force the count to zero (wins over en, suppresses term)
//   limit    : modulus; the count wraps after reaching limit-1
//   term     : high in the cycle the count wraps
module rate_counter #(
  parameter int unsigned CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic             term
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             at_end;

  assign at_end = (count_q == limit - CNT_W'(1));
  assign term   = en & ~clr & at_end;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = at_end ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Run/pause/step rate sequencer with selectable speed levels.
//   clk, rst     : clock, asynchronous active-high reset
//   start        : pulse, enter or resume RUN
//   stop         : pulse, RUN -> PAUSE
//   step         : pulse, single tick while not running
//   speed_up     : pulse, level + 1 (saturating)
//   speed_down   : pulse, level - 1 (saturating)
//   tick         : one-cycle advance enable, period BASE_DIV >> level
//   slow_clk     : toggles on every tick
//   speed_level  : current level
//   running      : high in RUN
//   tick_count   : 16-bit count of ticks, present only with TICK_CNT_EN defined
module tick_scheduler
  import tick_scheduler_pkg::*;
#(
  parameter int unsigned BASE_DIV   = DefaultBaseDiv,
  parameter int unsigned NUM_LEVELS = DefaultNumLevels,
  parameter int unsigned LVL_W      = 3,
  parameter int unsigned CNT_W      = 26,
  parameter int unsigned INIT_LEVEL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             speed_up,
  input  logic             speed_down,
  output logic             tick,
  output logic             slow_clk,
  output logic [LVL_W-1:0] speed_level,
  output logic             running
`ifdef TICK_CNT_EN
  ,
  output logic [15:0]      tick_count
`endif
);

  if ((BASE_DIV >> (NUM_LEVELS - 1)) < 2) begin : g_bad_base_div
    $error("BASE_DIV >> (NUM_LEVELS-1) must be at least 2");
  end
  if (((64'(BASE_DIV) - 64'd1) >> CNT_W) != 64'd0) begin : g_bad_cnt_w
    $error("CNT_W too narrow for BASE_DIV-1");
  end
  if (INIT_LEVEL >= NUM_LEVELS) begin : g_bad_init_level
    $error("INIT_LEVEL out of range");
  end

  localparam logic [LVL_W-1:0] MaxLevel  = LVL_W'(NUM_LEVELS - 1);
  localparam logic [LVL_W-1:0] InitLevel = LVL_W'(INIT_LEVEL);

  state_e           state_q, state_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             tick_q, tick_d;
  logic             slow_q, slow_d;
  logic             running_q;
  logic             lvl_inc, lvl_dec, lvl_change;
  logic             step_fire, term;
  logic [CNT_W-1:0] limit;

  // Opposing requests on the same edge cancel; saturated requests are no-ops.
  assign lvl_inc    = speed_up & ~speed_down & (level_q != MaxLevel);
  assign lvl_dec    = speed_down & ~speed_up & (level_q != '0);
  assign lvl_change = lvl_inc | lvl_dec;

  always_comb begin
    level_d = level_q;
    if (lvl_inc) begin
      level_d = level_q + LVL_W'(1);
    end else if (lvl_dec) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  // Limit follows the current level; a level change clears the counter on the same edge,
  // so the new limit governs from the next cycle on.
  assign limit = CNT_W'(calc_limit(32'(BASE_DIV), 8'(level_q)));

  rate_counter #(
    .CNT_W (CNT_W)
  ) u_rate_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (state_q == RUN),
    .clr   (lvl_change),
    .limit (limit),
    .term  (term)
  );

  // Priority stop > start > step; stop outside RUN is ignored but still masks start/step.
  always_comb begin
    state_d   = state_q;
    step_fire = 1'b0;
    case (state_q)
      IDLE, PAUSE: begin
        if (!stop) begin
          if (start) begin
            state_d = RUN;
          end else if (step) begin
            step_fire = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_d = PAUSE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tick_d = term | step_fire;
  assign slow_d = slow_q ^ tick_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      level_q   <= InitLevel;
      tick_q    <= 1'b0;
      slow_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      tick_q    <= tick_d;
      slow_q    <= slow_d;
      running_q <= (state_d == RUN);
    end
  end

  assign tick        = tick_q;
  assign slow_clk    = slow_q;
  assign speed_level = level_q;
  assign running     = running_q;

`ifdef TICK_CNT_EN
  logic [15:0] tick_cnt_q;

  // Restarts on a fresh run from IDLE; resuming from PAUSE keeps the tally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else if ((state_q == IDLE) && (state_d == RUN)) begin
      tick_cnt_q <= '0;
    end else if (tick_q) begin
      tick_cnt_q <= tick_cnt_q + 16'd1;
    end
  end

  assign tick_count = tick_cnt_q;
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
module tb_tick_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, step, speed_up, speed_down;
  logic       tick, slow_clk, running;
  logic [1:0] speed_level;
`ifdef TICK_CNT_EN
  logic [15:0] tick_count;
`endif

  tick_scheduler #(
    .BASE_DIV   (16),
    .NUM_LEVELS (4),
    .LVL_W      (2),
    .CNT_W      (5),
    .INIT_LEVEL (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .step        (step),
    .speed_up    (speed_up),
    .speed_down  (speed_down),
    .tick        (tick),
    .slow_clk    (slow_clk),
    .speed_level (speed_level),
    .running     (running)
`ifdef TICK_CNT_EN
    ,
    .tick_count  (tick_count)
`endif
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far; a tick registered at edge E is seen with cyc == E.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic       slow;
    logic [1:0] lvl;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic exp_slow = 1'b0;
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_tick(input int at, input logic [1:0] lvl);
    exp_slow = ~exp_slow;
    exp_q.push_back('{at: at, slow: exp_slow, lvl: lvl});
  endtask

  // Call just after a falling edge; the pulse is sampled at edge e = cyc + 1.
  task automatic pulse(input logic b_start, input logic b_stop, input logic b_step,
                       input logic b_up, input logic b_down, output int e);
    start = b_start; stop = b_stop; step = b_step; speed_up = b_up; speed_down = b_down;
    e = cyc + 1;
    @(negedge clk);
    start = 0; stop = 0; step = 0; speed_up = 0; speed_down = 0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Monitor: every observed tick must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst && tick) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_tick: tick=1 at cycle %0d, required no tick", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("tick_cycle", cyc, mon_e.at);
        check("tick_slow_clk", 32'(slow_clk), 32'(mon_e.slow));
        check("tick_level", 32'(speed_level), 32'(mon_e.lvl));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  int s, c1, c2, c3, c4, d1, d2, d3, d4, p, r, t, u, w, x, tmp;

  initial begin
    rst = 1; start = 0; stop = 0; step = 0; speed_up = 0; speed_down = 0;
    repeat (2) @(negedge clk);
    check("reset_tick", 32'(tick), 0);
    check("reset_slow_clk", 32'(slow_clk), 0);
    check("reset_level", 32'(speed_level), 0);
    check("reset_running", 32'(running), 0);
    rst = 0;

    // Level 0 run: period 16, first tick 16 edges after start.
    pulse(1, 0, 0, 0, 0, s);
    push_tick(s + 16, 0);
    push_tick(s + 32, 0);
    push_tick(s + 48, 0);
    check("run_running", 32'(running), 1);

    // Speed up mid-count: count restarts, period 8.
    wait_until(s + 52);
    pulse(0, 0, 0, 1, 0, c1);
    push_tick(c1 + 8, 1);
    check("level_after_up1", 32'(speed_level), 1);
    wait_until(c1 + 10);
    pulse(0, 0, 0, 1, 0, c2);
    pulse(0, 0, 0, 1, 0, c3);
    push_tick(c3 + 2, 3);
    push_tick(c3 + 4, 3);
    push_tick(c3 + 6, 3);
    push_tick(c3 + 8, 3);
    // Saturated request must not disturb the count.
    pulse(0, 0, 0, 1, 0, c4);
    check("level_saturated_hi", 32'(speed_level), 3);

    wait_until(c3 + 8);
    pulse(0, 0, 0, 0, 1, d1);
    pulse(0, 0, 0, 0, 1, d2);
    pulse(0, 0, 0, 0, 1, d3);
    push_tick(d3 + 16, 0);
    push_tick(d3 + 32, 0);
    pulse(0, 0, 0, 0, 1, d4);
    check("level_saturated_lo", 32'(speed_level), 0);

    // Stop with count at 5; counter holds 6 through the pause.
    wait_until(d3 + 37);
    pulse(0, 1, 0, 0, 0, p);
    check("pause_running", 32'(running), 0);
    wait_until(p + 50);
    pulse(1, 0, 0, 0, 0, r);
    push_tick(r + 10, 0);
    check("resume_running", 32'(running), 1);

    // Pause with count 2, then single step.
    wait_until(r + 11);
    pulse(0, 1, 0, 0, 0, tmp);
    wait_until(r + 15);
    push_tick(cyc + 1, 0);
    pulse(0, 0, 1, 0, 0, t);
    check("step_running", 32'(running), 0);

    // Resume from count 2; step in RUN ignored; stop+start together pauses at count 4.
    wait_until(t + 3);
    pulse(1, 0, 0, 0, 0, u);
    pulse(0, 0, 1, 0, 0, tmp);
    pulse(1, 1, 0, 0, 0, tmp);
    check("stop_start_running", 32'(running), 0);
    pulse(0, 0, 0, 1, 1, w);
    check("up_down_level", 32'(speed_level), 0);
    wait_until(w + 5);
    pulse(1, 0, 0, 0, 0, x);
    push_tick(x + 12, 0);

    // Level 1 after the tick; reset when the count reaches 7.
    wait_until(x + 12);
    pulse(0, 0, 0, 1, 0, tmp);
    check("pre_reset_level", 32'(speed_level), 1);
    wait_until(x + 20);
    check("pre_reset_slow_clk", 32'(slow_clk), 1);
`ifdef TICK_CNT_EN
    check("pre_reset_tick_count", 32'(tick_count), 13);
`endif
    rst = 1;
    #1;
    check("async_rst_tick", 32'(tick), 0);
    check("async_rst_slow_clk", 32'(slow_clk), 0);
    check("async_rst_level", 32'(speed_level), 0);
    check("async_rst_running", 32'(running), 0);
`ifdef TICK_CNT_EN
    check("async_rst_tick_count", 32'(tick_count), 0);
`endif
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (20) @(negedge clk);
    check("idle_after_reset_running", 32'(running), 0);
    check("pending_ticks", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
